axi_read_arbiter: RTL and testbench

//  Shares one AXI4 read port (AR/R) between NUM_HOSTS requesters (e.g. I$ refill, D$ refill, PTW).

---
 rtl/axi_pkg.sv | 38 +++
 rtl/axi_ar_slice.sv | 45 ++++
 rtl/axi_read_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// AXI4 read-channel types shared by the read arbiter and its AR register slice.
// Struct field widths follow the localparams below; the arbiter defaults to the same values.
package axi_pkg;

    localparam int unsigned AxiNumHosts   = 2;
    localparam int unsigned AxiAddrWidth  = 64;
    localparam int unsigned AxiDataWidth  = 64;
    localparam int unsigned AxiIdWidth    = 4;
    localparam int unsigned AxiDevIdWidth = AxiIdWidth + $clog2(AxiNumHosts);

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef logic [3:0] axi_cache_t;
    typedef logic [2:0] axi_prot_t;

    typedef struct packed {
        logic [AxiDevIdWidth-1:0] id;
        logic [AxiAddrWidth-1:0]  addr;
        logic [7:0]               len;
        logic [2:0]               size;
        axi_burst_t               burst;
        axi_cache_t               cache;
        axi_prot_t                prot;
    } axi_ar_t;

endpackage

// File: rtl/axi_ar_slice.sv
// Two-entry skid buffer for the AR channel: full throughput, all outputs driven from registers.
module axi_ar_slice
    import axi_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    in_valid_i,
    output logic    in_ready_o,
    input  axi_ar_t in_data_i,
    output logic    out_valid_o,
    input  logic    out_ready_i,
    output axi_ar_t out_data_o
);

    axi_ar_t    mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       push;
    logic       pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port; host index rides in the ARID MSBs.
// Define AXI_RD_ARB_AR_REG_EN to register the AR output through a 2-entry skid slice.
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned NUM_HOSTS    = AxiNumHosts,
    parameter int unsigned ADDR_WIDTH   = AxiAddrWidth,
    parameter int unsigned DATA_WIDTH   = AxiDataWidth,
    parameter int unsigned ID_WIDTH     = AxiIdWidth,
    localparam int unsigned HOST_IDX_W   = $clog2(NUM_HOSTS),
    localparam int unsigned DEV_ID_WIDTH = ID_WIDTH + HOST_IDX_W
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_HOSTS-1:0]           h_ar_valid_i,
    output logic [NUM_HOSTS-1:0]           h_ar_ready_o,
    input  logic [NUM_HOSTS*ID_WIDTH-1:0]  h_ar_id_i,
    input  logic [NUM_HOSTS*ADDR_WIDTH-1:0] h_ar_addr_i,
    input  logic [NUM_HOSTS*8-1:0]         h_ar_len_i,
    input  logic [NUM_HOSTS*3-1:0]         h_ar_size_i,
    input  logic [NUM_HOSTS*2-1:0]         h_ar_burst_i,
    input  logic [NUM_HOSTS*4-1:0]         h_ar_cache_i,
    input  logic [NUM_HOSTS*3-1:0]         h_ar_prot_i,
    output logic [NUM_HOSTS-1:0]           h_r_valid_o,
    input  logic [NUM_HOSTS-1:0]           h_r_ready_i,
    output logic [ID_WIDTH-1:0]            h_r_id_o,
    output logic [DATA_WIDTH-1:0]          h_r_data_o,
    output axi_resp_t                      h_r_resp_o,
    output logic                           h_r_last_o,
    output logic                           d_ar_valid_o,
    input  logic                           d_ar_ready_i,
    output logic [DEV_ID_WIDTH-1:0]        d_ar_id_o,
    output logic [ADDR_WIDTH-1:0]          d_ar_addr_o,
    output logic [7:0]                     d_ar_len_o,
    output logic [2:0]                     d_ar_size_o,
    output axi_burst_t                     d_ar_burst_o,
    output axi_cache_t                     d_ar_cache_o,
    output axi_prot_t                      d_ar_prot_o,
    input  logic                           d_r_valid_i,
    output logic                           d_r_ready_o,
    input  logic [DEV_ID_WIDTH-1:0]        d_r_id_i,
    input  logic [DATA_WIDTH-1:0]          d_r_data_i,
    input  axi_resp_t                      d_r_resp_i,
    input  logic                           d_r_last_i
);

    function automatic logic [HOST_IDX_W-1:0] rr_next(input logic [HOST_IDX_W-1:0] idx);
        return HOST_IDX_W'((32'(idx) + 1) % NUM_HOSTS);
    endfunction

    logic [HOST_IDX_W-1:0] rr_q;
    logic [HOST_IDX_W-1:0] pick;
    logic [HOST_IDX_W-1:0] cand;
    logic [HOST_IDX_W-1:0] sel;
    logic                  pick_found;
    axi_ar_t               ar_sel;
    axi_ar_t               ar_out;

    // First requesting host at or after the round-robin pointer.
    always_comb begin
        pick       = rr_q;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_HOSTS; i++) begin
            cand = HOST_IDX_W'((32'(rr_q) + i) % NUM_HOSTS);
            if (!pick_found && h_ar_valid_i[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        ar_sel.id    = {sel, h_ar_id_i[sel*ID_WIDTH +: ID_WIDTH]};
        ar_sel.addr  = h_ar_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
        ar_sel.len   = h_ar_len_i[sel*8 +: 8];
        ar_sel.size  = h_ar_size_i[sel*3 +: 3];
        ar_sel.burst = axi_burst_t'(h_ar_burst_i[sel*2 +: 2]);
        ar_sel.cache = h_ar_cache_i[sel*4 +: 4];
        ar_sel.prot  = h_ar_prot_i[sel*3 +: 3];
    end

`ifdef AXI_RD_ARB_AR_REG_EN
    logic slice_in_ready;

    assign sel = pick;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (pick_found && slice_in_ready) begin
            rr_q <= rr_next(pick);
        end
    end

    always_comb begin
        h_ar_ready_o       = '0;
        h_ar_ready_o[pick] = pick_found & slice_in_ready;
    end

    axi_ar_slice u_ar_slice (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (pick_found),
        .in_ready_o  (slice_in_ready),
        .in_data_i   (ar_sel),
        .out_valid_o (d_ar_valid_o),
        .out_ready_i (d_ar_ready_i),
        .out_data_o  (ar_out)
    );
`else
    typedef enum logic {StIdle, StGrant} state_e;

    state_e                state_q;
    logic [HOST_IDX_W-1:0] grant_q;
    logic                  ar_valid_q;

    // Grant is frozen while AR is presented so the device sees stable fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_q       <= '0;
            ar_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_q    <= pick;
                        ar_valid_q <= 1'b1;
                        state_q    <= StGrant;
                    end
                end
                StGrant: begin
                    if (d_ar_ready_i) begin
                        rr_q       <= rr_next(grant_q);
                        ar_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sel          = grant_q;
    assign ar_out       = ar_sel;
    assign d_ar_valid_o = ar_valid_q;

    always_comb begin
        h_ar_ready_o          = '0;
        h_ar_ready_o[grant_q] = ar_valid_q & d_ar_ready_i;
    end
`endif

    assign d_ar_id_o    = ar_out.id;
    assign d_ar_addr_o  = ar_out.addr;
    assign d_ar_len_o   = ar_out.len;
    assign d_ar_size_o  = ar_out.size;
    assign d_ar_burst_o = ar_out.burst;
    assign d_ar_cache_o = ar_out.cache;
    assign d_ar_prot_o  = ar_out.prot;

    logic [HOST_IDX_W-1:0] r_idx;

    assign r_idx = d_r_id_i[DEV_ID_WIDTH-1 -: HOST_IDX_W];

    always_comb begin
        h_r_valid_o = '0;
        d_r_ready_o = 1'b1;  // beats for a nonexistent host are drained
        if (32'(r_idx) < NUM_HOSTS) begin
            h_r_valid_o[r_idx] = d_r_valid_i;
            d_r_ready_o        = h_r_ready_i[r_idx];
        end
    end

    assign h_r_id_o   = d_r_id_i[ID_WIDTH-1:0];
    assign h_r_data_o = d_r_data_i;
    assign h_r_resp_o = d_r_resp_i;
    assign h_r_last_o = d_r_last_i;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized self-checking bench for axi_read_arbiter against a transaction-level model.
module tb_axi_read_arbiter;
    import axi_pkg::*;

    localparam int NH  = 2;
    localparam int IW  = 4;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int DIW = 5;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [3:0]    cache;
        logic [2:0]    prot;
    } req_t;

    typedef struct packed {
        logic [DIW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
        logic [3:0]     cache;
        logic [2:0]     prot;
    } dar_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NH-1:0]    h_ar_valid = '0;
    logic [NH-1:0]    h_ar_ready;
    logic [NH*IW-1:0] h_ar_id = '0;
    logic [NH*AW-1:0] h_ar_addr = '0;
    logic [NH*8-1:0]  h_ar_len = '0;
    logic [NH*3-1:0]  h_ar_size = '0;
    logic [NH*2-1:0]  h_ar_burst = '0;
    logic [NH*4-1:0]  h_ar_cache = '0;
    logic [NH*3-1:0]  h_ar_prot = '0;
    logic [NH-1:0]    h_r_valid;
    logic [NH-1:0]    h_r_ready = '0;
    logic [IW-1:0]    h_r_id;
    logic [DW-1:0]    h_r_data;
    axi_resp_t        h_r_resp;
    logic             h_r_last;
    logic             d_ar_valid;
    logic             d_ar_ready = 1'b0;
    logic [DIW-1:0]   d_ar_id;
    logic [AW-1:0]    d_ar_addr;
    logic [7:0]       d_ar_len;
    logic [2:0]       d_ar_size;
    axi_burst_t       d_ar_burst;
    axi_cache_t       d_ar_cache;
    axi_prot_t        d_ar_prot;
    logic             d_r_valid = 1'b0;
    logic             d_r_ready;
    logic [DIW-1:0]   d_r_id = '0;
    logic [DW-1:0]    d_r_data = '0;
    axi_resp_t        d_r_resp = RESP_OKAY;
    logic             d_r_last = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model state: pending host requests, expected device AR order, model round-robin pointer.
    req_t hq [NH][$];
    dar_t exp_q [$];
    int   model_rr = 0;

    // Last sampled cycle.
    logic          s_d_valid, s_d_ready, s_d_hs;
    logic [NH-1:0] s_h_ready, s_h_hs;
    dar_t          s_ar;

    always #5 clk = ~clk;

    axi_read_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .h_ar_valid_i (h_ar_valid),
        .h_ar_ready_o (h_ar_ready),
        .h_ar_id_i    (h_ar_id),
        .h_ar_addr_i  (h_ar_addr),
        .h_ar_len_i   (h_ar_len),
        .h_ar_size_i  (h_ar_size),
        .h_ar_burst_i (h_ar_burst),
        .h_ar_cache_i (h_ar_cache),
        .h_ar_prot_i  (h_ar_prot),
        .h_r_valid_o  (h_r_valid),
        .h_r_ready_i  (h_r_ready),
        .h_r_id_o     (h_r_id),
        .h_r_data_o   (h_r_data),
        .h_r_resp_o   (h_r_resp),
        .h_r_last_o   (h_r_last),
        .d_ar_valid_o (d_ar_valid),
        .d_ar_ready_i (d_ar_ready),
        .d_ar_id_o    (d_ar_id),
        .d_ar_addr_o  (d_ar_addr),
        .d_ar_len_o   (d_ar_len),
        .d_ar_size_o  (d_ar_size),
        .d_ar_burst_o (d_ar_burst),
        .d_ar_cache_o (d_ar_cache),
        .d_ar_prot_o  (d_ar_prot),
        .d_r_valid_i  (d_r_valid),
        .d_r_ready_o  (d_r_ready),
        .d_r_id_i     (d_r_id),
        .d_r_data_i   (d_r_data),
        .d_r_resp_i   (d_r_resp),
        .d_r_last_i   (d_r_last)
    );

    function automatic req_t rand_req();
        req_t r;
        r.id    = IW'($urandom);
        r.addr  = {32'($urandom), 32'($urandom)};
        r.len   = 8'($urandom);
        r.size  = 3'($urandom);
        r.burst = 2'($urandom_range(0, 3));
        r.cache = 4'($urandom);
        r.prot  = 3'($urandom);
        return r;
    endfunction

    // Round-robin over whole queues: each pick is the first non-empty host at/after the pointer.
    function automatic void plan();
        int   left [NH];
        int   taken [NH];
        int   total = 0;
        int   h;
        req_t r;
        dar_t e;
        for (int i = 0; i < NH; i++) begin
            left[i]  = hq[i].size();
            taken[i] = 0;
            total   += left[i];
        end
        for (int n = 0; n < total; n++) begin
            for (int off = 0; off < NH; off++) begin
                h = (model_rr + off) % NH;
                if (left[h] > 0) begin
                    r = hq[h][taken[h]];
                    e = '{id: {1'(h), r.id}, addr: r.addr, len: r.len, size: r.size,
                          burst: r.burst, cache: r.cache, prot: r.prot};
                    exp_q.push_back(e);
                    taken[h]++;
                    left[h]--;
                    model_rr = (h + 1) % NH;
                    break;
                end
            end
        end
    endfunction

    task automatic drive_hosts();
        req_t r;
        for (int h = 0; h < NH; h++) begin
            h_ar_valid[h] = (hq[h].size() > 0);
            if (hq[h].size() > 0) begin
                r = hq[h][0];
                h_ar_id[h*IW +: IW]    = r.id;
                h_ar_addr[h*AW +: AW]  = r.addr;
                h_ar_len[h*8 +: 8]     = r.len;
                h_ar_size[h*3 +: 3]    = r.size;
                h_ar_burst[h*2 +: 2]   = r.burst;
                h_ar_cache[h*4 +: 4]   = r.cache;
                h_ar_prot[h*3 +: 3]    = r.prot;
            end
        end
    endtask

    // Sample at negedge, advance past the posedge, retire accepted host requests.
    task automatic tick();
        @(negedge clk);
        s_d_valid = d_ar_valid;
        s_d_ready = d_ar_ready;
        s_d_hs    = d_ar_valid & d_ar_ready;
        s_h_ready = h_ar_ready;
        s_h_hs    = h_ar_valid & h_ar_ready;
        s_ar = '{id: d_ar_id, addr: d_ar_addr, len: d_ar_len, size: d_ar_size,
                 burst: d_ar_burst, cache: d_ar_cache, prot: d_ar_prot};
        @(posedge clk);
        #1;
        for (int h = 0; h < NH; h++) begin
            if (s_h_hs[h]) void'(hq[h].pop_front());
        end
        drive_hosts();
    endtask

    task automatic run_stream(input string name, input int budget, input bit rand_ready,
                              output int cycles);
        bit   prev_stall = 1'b0;
        dar_t prev = '0;
        dar_t e;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < budget) begin
            if (rand_ready) d_ar_ready = ($urandom_range(0, 2) != 0);
            tick();
            cycles++;
            if (prev_stall) begin
                checks++;
                if (s_d_valid !== 1'b1 || s_ar !== prev) begin
                    errors++;
                    $display("FAIL %s_stable: got valid=%b ar=%h, want valid=1 ar=%h",
                             name, s_d_valid, s_ar, prev);
                end
            end
            checks++;
            if ($countones(s_h_ready) > 1) begin
                errors++;
                $display("FAIL %s_ready_onehot: got %b, want at most one bit", name, s_h_ready);
            end
            if (s_d_hs) begin
                e = exp_q.pop_front();
                checks++;
                if (s_ar !== e) begin
                    errors++;
                    $display("FAIL %s_ar: got %h, want %h", name, s_ar, e);
                end
            end
            prev_stall = s_d_valid & ~s_d_ready;
            prev       = s_ar;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d ARs outstanding, want 0", name, exp_q.size());
            exp_q.delete();
            for (int h = 0; h < NH; h++) hq[h].delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        h_r_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (d_ar_valid !== 1'b0) begin
            errors++; $display("FAIL reset_d_ar_valid: got %b, want 0", d_ar_valid);
        end
        if (h_ar_ready !== 2'b00) begin
            errors++; $display("FAIL reset_h_ar_ready: got %b, want 00", h_ar_ready);
        end
        if (h_r_valid !== 2'b00) begin
            errors++; $display("FAIL reset_h_r_valid: got %b, want 00", h_r_valid);
        end
        rst = 1'b0;
        model_rr = 0;
    endtask

    task automatic test_single_host();
        req_t r;
        int   cyc;
        logic [DW-1:0] dat;
        r = '{id: 4'h3, addr: 64'h1000, len: 8'd3, size: 3'd3, burst: 2'b01, cache: 4'h0,
              prot: 3'h0};
        hq[0].push_back(r);
        plan();
        drive_hosts();
        d_ar_ready = 1'b1;
        run_stream("single", 20, 1'b0, cyc);
        for (int b = 0; b < 4; b++) begin
            dat       = {32'($urandom), 32'($urandom)};
            d_r_valid = 1'b1;
            d_r_id    = 5'h03;
            d_r_data  = dat;
            d_r_resp  = RESP_OKAY;
            d_r_last  = (b == 3);
            h_r_ready = 2'b11;
            #1;
            checks += 3;
            if (h_r_valid !== 2'b01) begin
                errors++; $display("FAIL single_r_valid: got %b, want 01", h_r_valid);
            end
            if (h_r_id !== 4'h3 || h_r_data !== dat) begin
                errors++; $display("FAIL single_r_beat: got id=%h data=%h, want id=3 data=%h",
                                   h_r_id, h_r_data, dat);
            end
            if (h_r_last !== (b == 3) || d_r_ready !== 1'b1) begin
                errors++; $display("FAIL single_r_last: got last=%b ready=%b, want last=%b ready=1",
                                   h_r_last, d_r_ready, (b == 3));
            end
            @(posedge clk);
            #1;
        end
        d_r_valid = 1'b0;
    endtask

    task automatic test_stall();
        int   cyc;
        dar_t e;
        hq[0].push_back(rand_req());
        hq[1].push_back(rand_req());
        plan();
        e = exp_q[0];
        d_ar_ready = 1'b0;
        drive_hosts();
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!s_d_valid && cyc < 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (s_d_valid !== 1'b1 || s_ar !== e) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b ar=%h, want valid=1 ar=%h",
                         s_d_valid, s_ar, e);
            end
`ifndef AXI_RD_ARB_AR_REG_EN
            checks++;
            if (s_h_ready !== 2'b00) begin
                errors++; $display("FAIL stall_h_ready: got %b, want 00", s_h_ready);
            end
`endif
        end
        d_ar_ready = 1'b1;
        run_stream("stall", 40, 1'b0, cyc);
    endtask

    task automatic test_random_ar();
        int cyc;
        for (int round = 0; round < 4; round++) begin
            for (int h = 0; h < NH; h++) begin
                int n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) hq[h].push_back(rand_req());
            end
            plan();
            drive_hosts();
            run_stream("random_ar", 400, 1'b1, cyc);
        end
        d_ar_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int want;
`ifdef AXI_RD_ARB_AR_REG_EN
        want = 17;
`else
        want = 32;
`endif
        for (int h = 0; h < NH; h++) begin
            for (int k = 0; k < 8; k++) hq[h].push_back(rand_req());
        end
        plan();
        d_ar_ready = 1'b1;
        drive_hosts();
        run_stream("b2b", 200, 1'b0, cyc);
        checks++;
        if (cyc != want) begin
            errors++; $display("FAIL b2b_cycles: got %0d, want %0d", cyc, want);
        end
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        hq[0].push_back(rand_req());
        plan();
        d_ar_ready = 1'b1;
        drive_hosts();
        run_stream("pre_reset", 20, 1'b0, cyc);
        hq[1].push_back(rand_req());
        plan();
        d_ar_ready = 1'b0;
        drive_hosts();
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!s_d_valid && cyc < 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int h = 0; h < NH; h++) hq[h].delete();
        exp_q.delete();
        drive_hosts();
        checks++;
        if (d_ar_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_valid: got %b, want 0", d_ar_valid);
        end
        model_rr = 0;
        hq[0].push_back(rand_req());
        hq[1].push_back(rand_req());
        plan();
        d_ar_ready = 1'b1;
        drive_hosts();
        run_stream("post_reset", 40, 1'b0, cyc);
    endtask

    task automatic test_r_interleave();
        d_r_valid = 1'b1;
        d_r_resp  = RESP_OKAY;
        d_r_last  = 1'b0;
        d_r_id    = 5'h12;
        h_r_ready = 2'b01;
        #1;
        checks += 2;
        if (h_r_valid !== 2'b10 || h_r_id !== 4'h2) begin
            errors++; $display("FAIL ileave_h1_route: got valid=%b id=%h, want valid=10 id=2",
                               h_r_valid, h_r_id);
        end
        if (d_r_ready !== 1'b0) begin
            errors++; $display("FAIL ileave_h1_stall: got %b, want 0", d_r_ready);
        end
        h_r_ready = 2'b11;
        #1;
        checks++;
        if (d_r_ready !== 1'b1) begin
            errors++; $display("FAIL ileave_h1_go: got %b, want 1", d_r_ready);
        end
        d_r_id    = 5'h02;
        h_r_ready = 2'b01;
        #1;
        checks += 2;
        if (h_r_valid !== 2'b01 || h_r_id !== 4'h2) begin
            errors++; $display("FAIL ileave_h0_route: got valid=%b id=%h, want valid=01 id=2",
                               h_r_valid, h_r_id);
        end
        if (d_r_ready !== 1'b1) begin
            errors++; $display("FAIL ileave_h0_ready: got %b, want 1", d_r_ready);
        end
        d_r_id    = 5'h13;
        d_r_resp  = RESP_SLVERR;
        d_r_last  = 1'b1;
        h_r_ready = 2'b10;
        #1;
        checks += 2;
        if (h_r_valid !== 2'b10 || d_r_ready !== 1'b1) begin
            errors++; $display("FAIL slverr_route: got valid=%b ready=%b, want valid=10 ready=1",
                               h_r_valid, d_r_ready);
        end
        if (h_r_resp !== RESP_SLVERR || h_r_last !== 1'b1) begin
            errors++; $display("FAIL slverr_fields: got resp=%b last=%b, want resp=10 last=1",
                               h_r_resp, h_r_last);
        end
        d_r_valid = 1'b0;
        d_r_last  = 1'b0;
        d_r_resp  = RESP_OKAY;
    endtask

    task automatic test_r_random();
        int            host;
        logic [NH-1:0] want_v;
        logic [DIW-1:0] id;
        logic [DW-1:0] dat;
        for (int i = 0; i < 40; i++) begin
            id        = DIW'($urandom);
            dat       = {32'($urandom), 32'($urandom)};
            d_r_valid = 1'($urandom);
            d_r_id    = id;
            d_r_data  = dat;
            d_r_resp  = axi_resp_t'(2'($urandom_range(0, 3)));
            d_r_last  = 1'($urandom);
            h_r_ready = NH'($urandom);
            host      = int'(id[DIW-1]);
            want_v    = '0;
            want_v[host] = d_r_valid;
            #1;
            checks += 3;
            if (h_r_valid !== want_v) begin
                errors++; $display("FAIL r_rand_valid: got %b, want %b", h_r_valid, want_v);
            end
            if (d_r_ready !== h_r_ready[host]) begin
                errors++; $display("FAIL r_rand_ready: got %b, want %b", d_r_ready,
                                   h_r_ready[host]);
            end
            if (h_r_id !== id[IW-1:0] || h_r_data !== dat || h_r_resp !== d_r_resp ||
                h_r_last !== d_r_last) begin
                errors++; $display("FAIL r_rand_fields: got id=%h data=%h, want id=%h data=%h",
                                   h_r_id, h_r_data, id[IW-1:0], dat);
            end
            @(posedge clk);
            #1;
        end
        d_r_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_host();
        test_stall();
        test_r_interleave();
        test_r_random();
        test_random_ar();
        test_back_to_back();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
